// File: rtl/bcd2bin_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// The master issues start/bcd_in; the slave returns busy/done/bin_out/err.
interface bcd2bin_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) ();

    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );

endinterface

// File: rtl/bcd2bin_seq.sv
// Multi-cycle BCD-to-binary converter using reverse double-dabble: one right
// shift plus per-digit "subtract 3 if >= 8" correction per cycle.
module bcd2bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    bcd2bin_seq_if.slave      bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Per-digit correction applied after each right shift; digits never borrow.
    function automatic logic [BCD_W-1:0] adjust_digits(input logic [BCD_W-1:0] value);
        logic [BCD_W-1:0] result;
        result = value;
        for (int d = 0; d < DIGITS; d++) begin
            if (value[4*d +: 4] >= 4'd8) begin
                result[4*d +: 4] = value[4*d +: 4] - 4'd3;
            end else begin
                result[4*d +: 4] = value[4*d +: 4];
            end
        end
        return result;
    endfunction

    // True when any nibble holds a non-decimal code (A-F).
    function automatic logic has_invalid_digit(input logic [BCD_W-1:0] value);
        logic found;
        found = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (value[4*d +: 4] > 4'd9) begin
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return found;
    endfunction

    state_t             state_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [BIN_W-1:0]   bin_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               err_pending_r;
    logic               done_r;
    logic [BIN_W-1:0]   bin_out_r;
    logic               err_r;

    logic [BCD_W-1:0]   bcd_next_s;
    logic [BIN_W-1:0]   bin_next_s;
    logic               busy_s;

    // One shift/correct step of the datapath, plus busy decode from state.
    always_comb begin
        bcd_next_s = adjust_digits({1'b0, bcd_r[BCD_W-1:1]});
        bin_next_s = {bcd_r[0], bin_r[BIN_W-1:1]};
        busy_s     = (state_r != IDLE) && (state_r != FINISH);
    end

    // Control FSM with registered datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            bcd_r         <= {BCD_W{1'b0}};
            bin_r         <= {BIN_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            err_pending_r <= 1'b0;
            done_r        <= 1'b0;
            bin_out_r     <= {BIN_W{1'b0}};
            err_r         <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                // FINISH accepts a new start so conversions can run back-to-back.
                IDLE, FINISH: begin
                    if (bus.start) begin
                        bcd_r         <= bus.bcd_in;
                        bin_r         <= {BIN_W{1'b0}};
                        cnt_r         <= {CNT_W{1'b0}};
                        err_pending_r <= has_invalid_digit(bus.bcd_in);
                        state_r       <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                // BIN_W shifting cycles, then one closing cycle that publishes the result.
                SHIFT: begin
                    if (cnt_r == CNT_W'(BIN_W)) begin
                        state_r   <= FINISH;
                        done_r    <= 1'b1;
                        bin_out_r <= err_pending_r ? {BIN_W{1'b0}} : bin_r;
                        err_r     <= err_pending_r;
                    end else begin
                        bcd_r   <= bcd_next_s;
                        bin_r   <= bin_next_s;
                        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_s;
    assign bus.done    = done_r;
    assign bus.bin_out = bin_out_r;
    assign bus.err     = err_r;

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Multi-cycle BCD-to-binary converter: packed BCD in, binary out. Inverse of the existing combinational binary-to-BCD path.
- Uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from every BCD digit that is >= 8.
- Used by score, counter and register-readback logic that receives operator or display-side BCD values and needs them as binary.
- Start/busy/done handshake, so one small datapath serves any digit count.

Parameters:
- DIGITS, 4, number of BCD digits in the input (input width 4*DIGITS).
- BIN_W, 14, output width. Must be >= ceil(log2(10^DIGITS)); default 14 covers 9999.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only when busy=0.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in bits [3:0]; sampled on the accepting edge.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse: bin_out and err are valid.
- bin_out  output  BIN_W  converted value; held until the next accepted start.
- err  output  1  at least one input nibble was > 9; held with bin_out.

Behaviour:
- Reset: on any rising edge with reset=1, every output clears to 0 (busy=0, done=0, bin_out=0, err=0) and the FSM goes to IDLE. Reset mid-conversion aborts it with no done pulse. Reset wins over start in the same cycle.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - On start=1, load the BCD shift register from bcd_in and clear the binary shift register and the iteration counter.
  - err_pending = OR over all nibbles of (nibble > 9).
  - Go to SHIFT; busy=1 from the next cycle.
- SHIFT, each cycle:
  - Shift the concatenation {bcd_reg, bin_reg} right by 1; the LSB of bcd_reg enters the MSB of bin_reg.
  - Then, per digit of the shifted bcd_reg: if digit >= 8, subtract 3 (4-bit arithmetic, no borrow between digits).
  - Both steps complete in one cycle.
  - Increment the counter. After exactly BIN_W SHIFT cycles, go to FINISH.
- FINISH (one cycle):
  - bin_out <= bin_reg, or 0 if err_pending; err <= err_pending.
  - done=1 for this cycle only; busy=0; return to IDLE.
- Latency: start accepted at edge T → busy high during cycles T+1..T+BIN_W+1 → done high in the cycle after edge T+BIN_W+1. Total BIN_W+2 cycles from accept to done.
- busy is a combinational decode of state: (state != IDLE) && (state != FINISH). This makes busy=0 in the FINISH cycle.
- start=1 in FINISH is accepted (back-to-back issue). Minimum issue interval is BIN_W+2 cycles.
- start while busy=1 is ignored and not queued. bcd_in changes while busy have no effect.
- Between conversions, bin_out and err hold their last values; done stays 0.
- For valid input, bcd_reg is 0 after BIN_W shifts. A nonzero residue is not checked (it cannot occur when the BIN_W rule holds).
- Invalid nibbles (A–F): conversion still runs the full latency; result is forced to 0 with err=1.

Test Plan:
- Reset, then start with bcd_in=16'h1234 → done exactly 16 cycles after the accepting edge; bin_out=1234 (14'h04D2), err=0; busy high for exactly 15 cycles.
- bcd_in=16'h9999 → bin_out=9999 (14'h270F). bcd_in=16'h0000 → bin_out=0. bcd_in=16'h0001 → bin_out=1. All with err=0.
- bcd_in=16'h12A4 → done after normal latency; bin_out=0, err=1. Next conversion of 16'h0042 → bin_out=42, err=0.
- Start 16'h0500, pulse start with 16'h0777 at cycle +5 → single done, bin_out=500. Assert start in the FINISH cycle with 16'h0777 → second done 16 cycles later, bin_out=777.
- Assert reset at cycle +7 of a conversion → no done pulse; all outputs 0 next cycle. A fresh start afterwards converts 16'h0321 → 321.
- Sweep all 10000 valid inputs against a reference model → all match, err=0, every done exactly 16 cycles after its start.
